// File: rtl/anemo_ram_dp.sv
// anemo_ram_dp: dual-port byte-enabled RAM with two Avalon-MM slaves.
// Shared clock enable, optional output register, sticky error flags.
module anemo_ram_dp #(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 12000,
  parameter int    ADDR_WIDTH = 14,
  parameter int    OUT_REG    = 0,
  parameter string INIT_FILE  = "anemo_ram_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    err_clr,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_oor,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_oor,
  output logic                    collision
);

  localparam int LANES = DATA_WIDTH / 8;

  logic en;
  logic [1:0] cs;
  logic [1:0] wr;
  logic [1:0] rd;
  logic [1:0] acc;
  logic [1:0] inr;
  logic [1:0] vout;
  logic [1:0] oor;
  logic       col;

  logic [ADDR_WIDTH-1:0] addr  [2];
  logic [LANES-1:0]      be    [2];
  logic [DATA_WIDTH-1:0] wdata [2];
  logic [DATA_WIDTH-1:0] dout  [2];

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign en = clken & ~reset_req;

  assign addr[0]  = s1_address;
  assign addr[1]  = s2_address;
  assign be[0]    = s1_byteenable;
  assign be[1]    = s2_byteenable;
  assign wdata[0] = s1_writedata;
  assign wdata[1] = s2_writedata;

  // a write strobe masks the read strobe
  assign cs  = {s2_chipselect, s1_chipselect} & {2{en}};
  assign wr  = cs & {s2_write, s1_write};
  assign rd  = cs & ~{s2_write, s1_write} & {s2_read, s1_read};
  assign acc = wr | rd;

  // s2 lanes first so s1 lanes override on a shared address
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (wr[1] && inr[1] && be[1][l])
        mem[addr[1]][l*8 +: 8] <= wdata[1][l*8 +: 8];
      if (wr[0] && inr[0] && be[0][l])
        mem[addr[0]][l*8 +: 8] <= wdata[0][l*8 +: 8];
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  v1;
    logic [DATA_WIDTH-1:0] d1;
    logic                  oor_r;

    assign inr[p] = 32'(addr[p]) < 32'(DEPTH);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v1 <= 1'b0;
        d1 <= '0;
      end else if (en) begin
        v1 <= rd[p];
        if (rd[p])
          d1 <= inr[p] ? mem[addr[p]] : '0;
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic                  v2;
      logic [DATA_WIDTH-1:0] d2;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v2 <= 1'b0;
          d2 <= '0;
        end else if (en) begin
          v2 <= v1;
          if (v1)
            d2 <= d1;
        end
      end

      assign vout[p] = v2;
      assign dout[p] = d2;
    end else begin : g_nreg
      assign vout[p] = v1;
      assign dout[p] = d1;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        oor_r <= 1'b0;
      else if (en) begin
        if (acc[p] && !inr[p])
          oor_r <= 1'b1;
        else if (err_clr)
          oor_r <= 1'b0;
      end
    end

    assign oor[p] = oor_r;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      col <= 1'b0;
    else if (en) begin
      if (wr[0] && wr[1] && addr[0] == addr[1])
        col <= 1'b1;
      else if (err_clr)
        col <= 1'b0;
    end
  end

  // a held result is only presented in an enabled cycle
  assign s1_readdatavalid = vout[0] & en;
  assign s2_readdatavalid = vout[1] & en;
  assign s1_readdata      = dout[0];
  assign s2_readdata      = dout[1];
  assign s1_oor           = oor[0];
  assign s2_oor           = oor[1];
  assign collision        = col;

endmodule
